// File: rtl/tmds_channel_decoder.sv
// TMDS 10b->8b channel decoder with bitslip-driven word alignment search.
// Define TMDS_DEC_STATS_EN to add the slip_pos_o and lock_loss_cnt_o statistics outputs.
module tmds_channel_decoder #(
   parameter int TOKEN_RUN = 8,
   parameter int TIMEOUT   = 2048
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [9:0] tmds_i,
   output logic       bitslip_o,
   output logic [7:0] data_o,
   output logic       de_o,
   output logic [1:0] ctrl_o,
`ifdef TMDS_DEC_STATS_EN
   output logic [3:0] slip_pos_o,
   output logic [7:0] lock_loss_cnt_o,
`endif
   output logic       locked_o
);

   localparam int RUN_W = $clog2(TOKEN_RUN + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TOKEN_RUN);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

   typedef enum logic [1:0] {SEARCH, SLIP, SETTLE, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d, run_next;
   logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
   logic [1:0]       settle_q, settle_d;
   logic [7:0]       data_q, data_d;
   logic             de_q, de_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic             is_tok;
   logic [1:0]       tok_val;

   function automatic logic [7:0] decode_data(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] o;
      d    = q[9] ? ~q[7:0] : q[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return o;
   endfunction

   always_comb begin
      is_tok  = 1'b1;
      tok_val = 2'b00;
      case (tmds_i)
         10'h354: tok_val = 2'b00;
         10'h0AB: tok_val = 2'b01;
         10'h154: tok_val = 2'b10;
         10'h2AB: tok_val = 2'b11;
         default: is_tok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      timer_d   = timer_q;
      settle_d  = settle_q;
      data_d    = 8'h00;
      de_d      = 1'b0;
      ctrl_d    = 2'b00;
      timer_inc = timer_q + 1'b1;
      run_next  = '0;
      if (is_tok) begin
         run_next = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end

      case (state_q)
         SEARCH: begin
            run_d   = run_next;
            timer_d = timer_inc;
            // Lock takes priority when it coincides with the search timeout.
            if (run_next == RUN_MAX) begin
               state_d = LOCKED;
               timer_d = '0;
            end else if (timer_inc == TMR_MAX) begin
               state_d = SLIP;
               timer_d = '0;
               run_d   = '0;
            end
         end
         SLIP: begin
            state_d  = SETTLE;
            settle_d = 2'd0;
            run_d    = '0;
            timer_d  = '0;
         end
         SETTLE: begin
            run_d    = '0;
            timer_d  = '0;
            settle_d = settle_q + 2'd1;
            if (settle_q == 2'd2) begin
               state_d = SEARCH;
            end
         end
         default: begin
            run_d = run_next;
            if (is_tok) begin
               timer_d = '0;
            end else begin
               timer_d = timer_inc;
               if (timer_inc == TMR_MAX) begin
                  state_d = SEARCH;
                  timer_d = '0;
                  run_d   = '0;
               end
            end
         end
      endcase

      // Outputs are qualified by the next state so the lock/unlock edge lines up with locked_o.
      if (state_d == LOCKED) begin
         if (is_tok) begin
            ctrl_d = tok_val;
         end else begin
            de_d   = 1'b1;
            data_d = decode_data(tmds_i);
            ctrl_d = ctrl_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= SEARCH;
         run_q    <= '0;
         timer_q  <= '0;
         settle_q <= 2'd0;
         data_q   <= 8'h00;
         de_q     <= 1'b0;
         ctrl_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         timer_q  <= timer_d;
         settle_q <= settle_d;
         data_q   <= data_d;
         de_q     <= de_d;
         ctrl_q   <= ctrl_d;
      end
   end

   assign bitslip_o = (state_q == SLIP);
   assign locked_o  = (state_q == LOCKED);
   assign data_o    = data_q;
   assign de_o      = de_q;
   assign ctrl_o    = ctrl_q;

`ifdef TMDS_DEC_STATS_EN
   logic [3:0] slip_pos_q, slip_pos_d;
   logic [7:0] lock_loss_q, lock_loss_d;

   always_comb begin
      slip_pos_d  = slip_pos_q;
      lock_loss_d = lock_loss_q;
      if (state_q == SLIP) begin
         slip_pos_d = (slip_pos_q == 4'd9) ? 4'd0 : slip_pos_q + 4'd1;
      end
      if (state_q == LOCKED && state_d == SEARCH && lock_loss_q != 8'hFF) begin
         lock_loss_d = lock_loss_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slip_pos_q  <= 4'd0;
         lock_loss_q <= 8'h00;
      end else begin
         slip_pos_q  <= slip_pos_d;
         lock_loss_q <= lock_loss_d;
      end
   end

   assign slip_pos_o      = slip_pos_q;
   assign lock_loss_cnt_o = lock_loss_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, decode, broken run, lock loss,
// bitslip alignment recovery and reset during SETTLE.
module tb_tmds_channel_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] tmds;
   logic       bitslip_o;
   logic [7:0] data_o;
   logic       de_o;
   logic [1:0] ctrl_o;
   logic       locked_o;
`ifdef TMDS_DEC_STATS_EN
   logic [3:0] slip_pos_o;
   logic [7:0] lock_loss_cnt_o;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   tmds_channel_decoder dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .tmds_i          (tmds),
      .bitslip_o       (bitslip_o),
      .data_o          (data_o),
      .de_o            (de_o),
      .ctrl_o          (ctrl_o),
`ifdef TMDS_DEC_STATS_EN
      .slip_pos_o      (slip_pos_o),
      .lock_loss_cnt_o (lock_loss_cnt_o),
`endif
      .locked_o        (locked_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [9:0] rotr(input logic [9:0] w, input int r);
      logic [19:0] x;
      x = {w, w} >> r;
      return x[9:0];
   endfunction

   task automatic drive(input logic [9:0] w);
      tmds = w;
      tick();
   endtask

   initial begin
      int rot;
      int npulse;
      int lock_tick;
      int found;
      int highs;
      int pulse_tick [3];

      rst  = 1'b1;
      tmds = 10'h1FF;
      tick();
      tick();
      chk("rst_bitslip", bitslip_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_de", de_o, 0);
      chk("rst_ctrl", ctrl_o, 0);
      chk("rst_locked", locked_o, 0);
      rst = 1'b0;

      // Aligned lock on a clean 0x354 stream
      for (int n = 1; n <= 20; n++) begin
         drive(10'h354);
         chk("lock_locked", locked_o, (n >= 8) ? 1 : 0);
         chk("lock_de", de_o, 0);
         chk("lock_ctrl", ctrl_o, 0);
         chk("lock_bitslip", bitslip_o, 0);
      end

      // Data decode while locked
      drive(10'h100);
      chk("dec_100_data", data_o, 8'h00);
      chk("dec_100_de", de_o, 1);
      drive(10'h1FF);
      chk("dec_1ff_data", data_o, 8'h01);
      chk("dec_1ff_de", de_o, 1);
      drive(10'h2AB);
      chk("tok_2ab_de", de_o, 0);
      chk("tok_2ab_ctrl", ctrl_o, 2'b11);
      chk("tok_2ab_data", data_o, 8'h00);
      drive(10'h0F0);
      chk("dec_0f0_data", data_o, 8'hEE);
      chk("dec_hold_ctrl", ctrl_o, 2'b11);
      drive(10'h2F0);
      chk("dec_2f0_data", data_o, 8'hEF);
      drive(10'h3F0);
      chk("dec_3f0_data", data_o, 8'h11);
      chk("dec_3f0_de", de_o, 1);

      // Lock loss after 2048 consecutive data words
      drive(10'h0AB);
      chk("loss_tok_ctrl", ctrl_o, 2'b01);
      for (int n = 1; n <= 2047; n++) drive(10'h1FF);
      chk("loss_2047_locked", locked_o, 1);
      chk("loss_2047_de", de_o, 1);
      chk("loss_2047_ctrl", ctrl_o, 2'b01);
      drive(10'h1FF);
      chk("loss_locked", locked_o, 0);
      chk("loss_de", de_o, 0);
      chk("loss_data", data_o, 8'h00);
      chk("loss_ctrl", ctrl_o, 2'b00);
`ifdef TMDS_DEC_STATS_EN
      chk("loss_cnt", lock_loss_cnt_o, 1);
`endif

      // Broken run: 7 tokens, a data word, then 8 tokens
      reset_dut();
      for (int n = 1; n <= 7; n++) drive(10'h154);
      chk("brk_7_locked", locked_o, 0);
      drive(10'h100);
      chk("brk_data_locked", locked_o, 0);
      for (int n = 1; n <= 7; n++) drive(10'h154);
      chk("brk_15_locked", locked_o, 0);
      chk("brk_15_ctrl", ctrl_o, 2'b00);
      drive(10'h154);
      chk("brk_16_locked", locked_o, 1);
      chk("brk_16_ctrl", ctrl_o, 2'b10);

      // Misaligned stream: rotate back by one bit on each bitslip pulse
      reset_dut();
      rot       = 3;
      npulse    = 0;
      lock_tick = 0;
      for (int n = 1; n <= 8000 && lock_tick == 0; n++) begin
         drive(rotr(10'h354, rot));
         if (bitslip_o) begin
            if (npulse < 3) pulse_tick[npulse] = n;
            npulse++;
            if (rot > 0) rot--;
         end
         if (locked_o) lock_tick = n;
      end
      chk("slip_count", npulse, 3);
      chk("slip_tick0", pulse_tick[0], 2048);
      chk("slip_tick1", pulse_tick[1], 4100);
      chk("slip_tick2", pulse_tick[2], 6152);
      chk("slip_lock_tick", lock_tick, 6164);
`ifdef TMDS_DEC_STATS_EN
      chk("slip_pos", slip_pos_o, 3);
`endif

      // Reset asserted while in SETTLE
      reset_dut();
      found = 0;
      for (int n = 1; n <= 3000 && found == 0; n++) begin
         drive(10'h100);
         if (bitslip_o) found = n;
      end
      chk("settle_slip_tick", found, 2048);
      drive(10'h100);
      chk("settle_bitslip", bitslip_o, 0);
      rst = 1'b1;
      drive(10'h100);
      rst = 1'b0;
      chk("settle_rst_bitslip", bitslip_o, 0);
      chk("settle_rst_locked", locked_o, 0);
      chk("settle_rst_de", de_o, 0);
      chk("settle_rst_data", data_o, 0);
      chk("settle_rst_ctrl", ctrl_o, 0);
      highs = 0;
      for (int n = 1; n <= 2047; n++) begin
         drive(10'h100);
         if (bitslip_o) highs++;
      end
      chk("settle_quiet", highs, 0);
      drive(10'h100);
      chk("settle_next_slip", bitslip_o, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
